// File: rtl/fft_seq_ctrl_if.sv
// Host-side bundle for the FFT sequencer: start/step requests in, and out the phase strobes,
// status and butterfly addresses.
interface fft_seq_ctrl_if #(
    parameter int LOG2N = 3
);
    localparam int SW = $clog2(LOG2N) + 1;

    logic             start;
    logic             ReadyIn;
    logic             busy;
    logic             done;
    logic             load_w;
    logic             load_b;
    logic             mul_en;
    logic             load_a;
    logic             cal_en;
    logic             wr_en;
    logic [SW-1:0]    stage;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;

    modport master (
        input  start, ReadyIn,
        output busy, done, load_w, load_b, mul_en, load_a, cal_en, wr_en,
        output stage, addr_a, addr_b, tw_idx
    );

    modport slave (
        output start, ReadyIn,
        input  busy, done, load_w, load_b, mul_en, load_a, cal_en, wr_en,
        input  stage, addr_a, addr_b, tw_idx
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Radix-2 DIT FFT sequencer: walks six phases per butterfly over all stages and butterflies.
// Build option FFT_SEQ_STEP_EN: phases advance only on ReadyIn rising edges; otherwise every clock.
module fft_seq_ctrl #(
    parameter int LOG2N = 3
) (
    input  logic          clk,
    input  logic          Rst,
    fft_seq_ctrl_if.master bus
);
    localparam int SW = $clog2(LOG2N) + 1;
    localparam int KW = LOG2N - 1;
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
    localparam logic [KW-1:0]    K_LAST = {KW{1'b1}};
    localparam logic [LOG2N-1:0] ONE_N  = LOG2N'(1);

    typedef enum logic [2:0] {
        IDLE, LD_W, LD_B, MUL, LD_A, CAL, WR, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic          step;

`ifdef FFT_SEQ_STEP_EN
    logic ready_q, ready_d;

    always_comb begin
        ready_d = bus.ReadyIn;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    // A held-high ReadyIn yields a single step.
    assign step = bus.ReadyIn & ~ready_q;
`else
    logic unused_ready;
    assign unused_ready = bus.ReadyIn;
    assign step         = 1'b1;
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LD_W;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            LD_W: if (step) state_d = LD_B;
            LD_B: if (step) state_d = MUL;
            MUL:  if (step) state_d = LD_A;
            LD_A: if (step) state_d = CAL;
            CAL:  if (step) state_d = WR;
            WR: begin
                if (step) begin
                    if (k_q != K_LAST) begin
                        k_d     = k_q + KW'(1);
                        state_d = LD_W;
                    end else if (s_q != S_LAST) begin
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                        state_d = LD_W;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q != IDLE);
        bus.done   = (state_q == DONE);
        bus.load_w = (state_q == LD_W);
        bus.load_b = (state_q == LD_B);
        bus.mul_en = (state_q == MUL);
        bus.load_a = (state_q == LD_A);
        bus.cal_en = (state_q == CAL);
        bus.wr_en  = (state_q == WR);
        bus.stage  = s_q;
    end

    // Addresses depend only on registered s/k, so they hold steady across all six phases.
    logic [LOG2N-1:0] k_ext, half, pos, grp, base;
    logic [SW-1:0]    tw_sh;

    always_comb begin
        k_ext      = {1'b0, k_q};
        half       = ONE_N << s_q;
        pos        = k_ext & (half - ONE_N);
        grp        = k_ext >> s_q;
        base       = (grp << 1) << s_q;
        tw_sh      = S_LAST - s_q;
        bus.addr_a = base | pos;
        bus.addr_b = (base | pos) + half;
        // pos < 2^s <= N/2, so its low LOG2N-1 bits carry the whole value.
        bus.tw_idx = pos[LOG2N-2:0] << tw_sh;
    end
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Randomized bench for fft_seq_ctrl: an N=8 and an N=4 instance share stimulus and are
// compared every cycle against a phase-counter model, plus literal timing/address checks.
module tb_fft_seq_ctrl;
    logic clk      = 1'b0;
    logic Rst      = 1'b0;
    logic start    = 1'b0;
    logic ready_in = 1'b0;
    bit   chk_en   = 1'b0;
    int   n_chk    = 0;
    int   n_fail   = 0;

`ifdef FFT_SEQ_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif
    localparam logic [63:0] RST_V = 64'h0000_0000_0001_0000;

    always #5 clk = ~clk;

    fft_seq_ctrl_if #(.LOG2N(3)) bus3 ();
    fft_seq_ctrl_if #(.LOG2N(2)) bus2 ();
    assign bus3.start   = start;
    assign bus3.ReadyIn = ready_in;
    assign bus2.start   = start;
    assign bus2.ReadyIn = ready_in;

    fft_seq_ctrl #(.LOG2N(3)) dut3 (.clk(clk), .Rst(Rst), .bus(bus3));
    fft_seq_ctrl #(.LOG2N(2)) dut2 (.clk(clk), .Rst(Rst), .bus(bus2));

    // Packed view: busy, done, 6 strobes, stage(8), addr_a(16), addr_b(16), tw_idx(16)
    logic [63:0] act [2];
    assign act[0] = {bus3.busy, bus3.done, bus3.load_w, bus3.load_b, bus3.mul_en,
                     bus3.load_a, bus3.cal_en, bus3.wr_en, 8'(bus3.stage),
                     16'(bus3.addr_a), 16'(bus3.addr_b), 16'(bus3.tw_idx)};
    assign act[1] = {bus2.busy, bus2.done, bus2.load_w, bus2.load_b, bus2.mul_en,
                     bus2.load_a, bus2.cal_en, bus2.wr_en, 8'(bus2.stage),
                     16'(bus2.addr_a), 16'(bus2.addr_b), 16'(bus2.tw_idx)};

    // Model: mode 0 idle, 1 running at linear phase index p, 2 done; hs/hk hold last s/k.
    int L [2] = '{3, 2};
    int m_mode [2];
    int m_p    [2];
    int m_hs   [2];
    int m_hk   [2];
    bit m_prev;

    always @(posedge clk or posedge Rst) begin
        bit stp;
        if (Rst) begin
            for (int d = 0; d < 2; d++) begin
                m_mode[d] = 0; m_p[d] = 0; m_hs[d] = 0; m_hk[d] = 0;
            end
            m_prev = 1'b0;
        end else begin
            stp    = STEP_MODE ? (ready_in && !m_prev) : 1'b1;
            m_prev = ready_in;
            for (int d = 0; d < 2; d++) begin
                int h;
                int tot;
                h   = 1 << (L[d] - 1);
                tot = 6 * h * L[d];
                case (m_mode[d])
                    0: if (start) begin m_mode[d] = 1; m_p[d] = 0; end
                    1: if (stp) begin
                        if (m_p[d] == tot - 1) m_mode[d] = 2;
                        else m_p[d] = m_p[d] + 1;
                    end
                    default: m_mode[d] = 0;
                endcase
                if (m_mode[d] == 1) begin
                    m_hs[d] = m_p[d] / (6 * h);
                    m_hk[d] = (m_p[d] / 6) % h;
                end
            end
        end
    end

    function automatic logic [63:0] expv(int l2n, int mode, int p, int hs, int hk);
        int h, s, k, ph, half, pos, grp, a, b, tw;
        logic [5:0] strb;
        h = 1 << (l2n - 1);
        if (mode == 1) begin
            ph = p % 6; s = p / (6 * h); k = (p / 6) % h;
            strb = 6'b100000 >> ph;
        end else begin
            s = hs; k = hk; strb = 6'b000000;
        end
        half = 2 ** s;
        pos  = k % half;
        grp  = k / half;
        a    = grp * 2 * half + pos;
        b    = a + half;
        tw   = pos * (2 ** (l2n - 1 - s));
        return {mode != 0, mode == 2, strb, 8'(s), 16'(a), 16'(b), 16'(tw)};
    endfunction

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
        end
    endtask

    int lit_s [4] = '{0, 1, 1, 2};
    int lit_k [4] = '{1, 1, 2, 3};
    int lit_a [4] = '{2, 1, 4, 3};
    int lit_b [4] = '{3, 3, 6, 7};
    int lit_t [4] = '{0, 2, 0, 3};

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    int h, s, k, ph;
                    chk($sformatf("cycle_n%0d", 1 << L[d]), act[d],
                        expv(L[d], m_mode[d], m_p[d], m_hs[d], m_hk[d]));
                    h  = 1 << (L[d] - 1);
                    ph = m_p[d] % 6;
                    s  = m_p[d] / (6 * h);
                    k  = (m_p[d] / 6) % h;
                    if (m_mode[d] == 1 && d == 0 && ph == 0) begin
                        for (int i = 0; i < 4; i++) begin
                            if (s == lit_s[i] && k == lit_k[i])
                                chk($sformatf("addr_lit_s%0dk%0d", s, k), act[0][47:0],
                                    {16'(lit_a[i]), 16'(lit_b[i]), 16'(lit_t[i])});
                        end
                    end
                    if (m_mode[d] == 1 && d == 1 && ph == 5 && s == 1 && k == 1)
                        chk("last_wr_n4", {act[1][56], act[1][47:0]}, {1'b1, 16'd1, 16'd3, 16'd1});
                end
            end
        end
    endtask

    initial begin
        int done_c, done2_c, ndone, wr, found;
        fork
            compare_loop();
        join_none

        #1 Rst = 1'b1;
        #1;
        chk("reset_state_n8", act[0], RST_V);
        chk("reset_state_n4", act[1], RST_V);
        @(posedge clk); #1 Rst = 1'b0;
        chk_en = 1'b1;

`ifndef FFT_SEQ_STEP_EN
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_rise", 64'(bus3.busy), 64'd1);
        done_c = 0; done2_c = 0; ndone = 0; wr = 0;
        for (int c = 1; c <= 80; c++) begin
            if (bus3.done) begin ndone++; done_c = c; end
            if (bus2.done) done2_c = c;
            if (bus3.wr_en) wr++;
            start = bus3.cal_en && (c < 20);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_latency_n8", 64'(done_c), 64'd73);
        chk("done_count_n8", 64'(ndone), 64'd1);
        chk("wr_count_n8", 64'(wr), 64'd12);
        chk("done_latency_n4", 64'(done2_c), 64'd25);
`else
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; ready_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("step_hold_ldb", 64'(bus3.load_b), 64'd1);
        chk("step_hold_no_mul", 64'(bus3.mul_en), 64'd0);
        ready_in = 1'b0;
        @(posedge clk); #1 ready_in = 1'b1;
        @(posedge clk); #1;
        chk("step_edge_mul", 64'(bus3.mul_en), 64'd1);
        ready_in = 1'b0;
`endif

        // Reset in the middle of (s1,k2,MUL): p = 24 + 12 + 2
        found = 0;
        for (int c = 0; c < 5000 && found == 0; c++) begin
            @(posedge clk); #1;
            if (m_mode[0] == 1 && m_p[0] == 38) found = 1;
            else begin
                start    = (m_mode[0] == 0);
                ready_in = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        chk("reach_s1k2_mul", 64'(found), 64'd1);
        Rst = 1'b1;
        #1;
        chk("rst_outputs_zero", {act[0][63:32]}, 32'd0);
        @(posedge clk); #1 Rst = 1'b0; ready_in = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart_ldw_s0k0", {act[0][61], act[0][55:0]}, {1'b1, 8'd0, 16'd0, 16'd1, 16'd0});

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start    = ($urandom_range(0, 9) == 0);
            ready_in = 1'($urandom_range(0, 1));
            if (Rst) Rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) Rst = 1'b1;
        end
        Rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
